// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-source tags, lane-enable encodings and
// default register-file geometry.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 3;

  localparam logic SRC_PIPE  = 1'b0;
  localparam logic SRC_DEBUG = 1'b1;

  // Lane enables: bit1 covers data[31:16], bit0 covers data[15:0].
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_FULL = 2'b11;

  function automatic logic we_any(input logic [1:0] we);
    return we != WE_NONE;
  endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Two-entry debug write queue. Slot 0 is always the head; a pop shifts
// slot 1 down, so a simultaneous push at count 1 lands directly in the head.
module regfile_wr_fifo
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [1:0]        push_we,
  input  logic [REG_AW-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        head_we,
  output logic [REG_AW-1:0] head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  logic [1:0][1:0]        we_q;
  logic [1:0][REG_AW-1:0] reg_q;
  logic [1:0][DATA_W-1:0] data_q;
  logic                   do_push;
  logic                   do_pop;
  logic                   wr_idx;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next free slot, accounting for the shift a same-cycle pop causes.
  assign wr_idx = !((count == 2'd0) || ((count == 2'd1) && do_pop));

  assign head_we   = we_q[0];
  assign head_reg  = reg_q[0];
  assign head_data = data_q[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      we_q   <= '0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      if (do_pop) begin
        we_q[0]   <= we_q[1];
        reg_q[0]  <= reg_q[1];
        data_q[0] <= data_q[1];
      end
      if (do_push) begin
        we_q[wr_idx]   <= push_we;
        reg_q[wr_idx]  <= push_reg;
        data_q[wr_idx] <= push_data;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: pipeline writes win immediately, debug
// writes queue and drain into idle cycles, with a stall request on starvation.
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_AW       = DEF_REG_AW,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        pipe_we,
  input  logic [REG_AW-1:0] pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [1:0]        dbg_we,
  input  logic [REG_AW-1:0] dbg_reg,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              pipe_stall,
  output logic [1:0]        rf_we,
  output logic [REG_AW-1:0] rf_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_source,
  output logic [1:0]        fifo_count,
  output logic              stall_violation
);

  localparam logic [7:0] STARVE_TOP = 8'(STARVE_LIMIT - 1);

  logic [1:0]        head_we;
  logic [REG_AW-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              grant_pipe;
  logic              grant_dbg;
  logic              violation;
  logic [7:0]        starve_cnt;

  assign dbg_ready  = !fifo_full;
  // All-lanes-off debug requests are handshaken but never occupy a slot.
  assign fifo_push  = dbg_valid && dbg_ready && we_any(dbg_we);
  assign grant_pipe = we_any(pipe_we);
  assign grant_dbg  = !grant_pipe && !fifo_empty;
  assign violation  = pipe_stall && grant_pipe;

  regfile_wr_fifo #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_we   (dbg_we),
    .push_reg  (dbg_reg),
    .push_data (dbg_data),
    .pop       (grant_dbg),
    .head_we   (head_we),
    .head_reg  (head_reg),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Starvation tracking: counts cycles the head has been passed over.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt      <= 8'd0;
      pipe_stall      <= 1'b0;
      stall_violation <= 1'b0;
    end else begin
      pipe_stall <= 1'b0;
      if (fifo_empty || grant_dbg || violation) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt == STARVE_TOP) begin
        starve_cnt <= 8'd0;
        pipe_stall <= 1'b1;
      end else if (starve_cnt != 8'hFF) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      if (violation) stall_violation <= 1'b1;
    end
  end

  // Write-port register; source/reg/data hold on idle cycles for the status view.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we     <= WE_NONE;
      rf_reg    <= '0;
      rf_data   <= '0;
      rf_source <= SRC_PIPE;
    end else if (grant_pipe) begin
      rf_we     <= pipe_we;
      rf_reg    <= pipe_reg;
      rf_data   <= pipe_data;
      rf_source <= SRC_PIPE;
    end else if (grant_dbg) begin
      rf_we     <= head_we;
      rf_reg    <= head_reg;
      rf_data   <= head_data;
      rf_source <= SRC_DEBUG;
    end else begin
      rf_we <= WE_NONE;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the single register-file write port between the pipeline writeback stage and a debug/loader write requester. Pipeline writes always take the port in the cycle they arrive. Debug writes are buffered in a 2-entry FIFO and drain into idle cycles. A starvation counter requests a one-cycle pipeline stall when debug writes have waited too long. The block sits between the writeback stage and the register file and replaces the writeback stage's direct drive of the write port.

## Interface
Parameters:
- DATA_W, 32: write data width.
- REG_AW, 3: register encoding width (8 registers).
- STARVE_LIMIT, 8: consecutive cycles the FIFO head may wait before a stall is requested; legal range 2..255.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pipe_we  in  2  writeback enable from the pipeline; bit1 = upper 16 bits, bit0 = lower 16 bits; 2'b00 = no write.
- pipe_reg  in  REG_AW  pipeline destination register.
- pipe_data  in  DATA_W  pipeline writeback data.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  FIFO can accept; a request is accepted on a rising edge where dbg_valid && dbg_ready.
- dbg_we  in  2  debug lane enables, same encoding as pipe_we.
- dbg_reg  in  REG_AW  debug destination register.
- dbg_data  in  DATA_W  debug write data.
- pipe_stall  out  1  one-cycle request that the pipeline present pipe_we = 0 in this cycle.
- rf_we  out  2  register-file write enable.
- rf_reg  out  REG_AW  register-file destination.
- rf_data  out  DATA_W  register-file write data.
- rf_source  out  1  0 = pipeline, 1 = debug; qualifies the rf_* outputs, used by the VGA status view.
- fifo_count  out  2  debug FIFO occupancy, 0..2.
- stall_violation  out  1  sticky error flag; cleared only by reset.

## Operation
- FIFO:
  - Depth 2, entries {we, reg, data}.
  - dbg_ready = (fifo_count != 2), derived combinationally from the count.
  - Accepted requests with dbg_we == 2'b00 are consumed but not enqueued.
  - When full, dbg_ready = 0 even if a dequeue occurs in the same cycle; there is no same-cycle enqueue into a full FIFO.
  - An empty FIFO with dbg_valid: the entry is enqueued and becomes eligible next cycle. There is no bypass.
- Grant, evaluated each cycle:
  - If pipe_we != 0, the pipeline is granted and its fields are registered to rf_* with rf_source = 0.
  - Else if the FIFO is non-empty, the head is dequeued and registered to rf_* with rf_source = 1.
  - Else rf_we <= 0; rf_reg, rf_data and rf_source hold their values.
- Starvation counter (8 bits, saturating):
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise increments by 1 each cycle.
  - When the counter reaches STARVE_LIMIT-1 and increments again, pipe_stall is set for the next cycle only.
  - The counter then clears.
- Stall contract: while pipe_stall = 1 the pipeline must drive pipe_we = 0, so the FIFO head is granted.
  - If pipe_we != 0 while pipe_stall = 1, the pipeline still wins and stall_violation is set.
  - The counter restarts from 0 in that case.
- Simultaneous enqueue and dequeue at count 1: count stays 1 and the new entry becomes the head.

## Timing
- All outputs are registered except dbg_ready.
- Latency: pipeline inputs at edge N appear on rf_* after edge N, i.e. one cycle.
- Debug path: accept at edge N, earliest grant at edge N+1, earliest rf_we visible after edge N+1.
- Worst-case debug wait from head to grant is STARVE_LIMIT+1 cycles, provided the stall contract is honoured.
- Reset (asynchronous, on reset_n low):
  - rf_we = 0, rf_reg = 0, rf_data = 0, rf_source = 0.
  - pipe_stall = 0, fifo_count = 0, stall_violation = 0, counter = 0.
  - dbg_ready = 1 once the FIFO is empty.
- Reset mid-operation discards FIFO contents and any pending stall. There is no partial write.

## Structure
- Shared package (cpu_pkg) holds:
  - SRC_PIPE = 1'b0 and SRC_DEBUG = 1'b1.
  - The 2-bit lane-enable encoding constants (WE_NONE, WE_LO, WE_HI, WE_FULL).
  - DATA_W and REG_AW defaults.
- Sub-module regfile_wr_fifo holds the 2-entry FIFO: push/pop, head outputs, count, full/empty.
- The arbiter holds grant logic, the starvation counter and the output registers.

## Test plan
- Reset with reset_n = 0 mid-stream, FIFO holding 2 entries -> all outputs 0 asynchronously, fifo_count = 0, dbg_ready = 1, and no rf_we pulse after release.
- pipe_we = 2'b11, reg 5, data 0xDEADBEEF, no debug traffic -> next cycle rf_we = 3, rf_reg = 5, rf_data = 0xDEADBEEF, rf_source = 0.
- Idle pipeline, debug writes {3, reg 2, 0x11} then {1, reg 7, 0x22} on consecutive cycles -> rf_source = 1 writes in the same order, one cycle after each becomes head, and fifo_count returns to 0.
- Debug push while pipe_we = 3 every cycle, STARVE_LIMIT = 8:
  - pipe_stall pulses exactly once after 8 waiting cycles.
  - The bench drives pipe_we = 0 in that cycle.
  - The head is written next cycle with rf_source = 1.
- Same setup, but the bench keeps pipe_we = 3 during pipe_stall -> pipeline wins, stall_violation = 1 and stays set, and the counter restarts.
- Fill the FIFO with 2 entries while the pipeline is busy -> dbg_ready = 0 and a third dbg_valid is held off; on the first idle pipeline cycle the head drains and dbg_ready = 1 the following cycle. An accepted request with dbg_we = 0 leaves fifo_count unchanged.
